// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer modules and the argmax stage.
package fc_pkg;

  // Control states of the sequential argmax scanner.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } argmax_state_t;

  // Width of an FC layer output: full product width plus accumulation growth.
  function automatic int fc_out_width(input int width, input int in_cnt);
    return 2 * width + $clog2(in_cnt);
  endfunction

endpackage

// File: rtl/fc_argmax.sv
// Sequential argmax over the final FC layer outputs: captures the vector on an
// input handshake, scans one element per cycle, and presents the index and value
// of the largest signed element on an output handshake.
module fc_argmax
  import fc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IN    = 84,
  parameter int OUT   = 10,
  localparam int ZW   = fc_out_width(WIDTH, IN),
  localparam int CW   = (OUT > 1) ? $clog2(OUT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [ZW-1:0] z [0:OUT-1],
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_class,
  output logic [ZW-1:0] out_max
);

  localparam logic [CW-1:0] LAST_IDX = CW'(OUT - 1);

  argmax_state_t state_reg, state_next;

  logic        [ZW-1:0] buf_reg [0:OUT-1];
  logic signed [ZW-1:0] best_reg;
  logic        [CW-1:0] idx_reg;
  logic        [CW-1:0] cnt_reg;

  logic                 accept;
  logic                 last;
  logic signed [ZW-1:0] cand;
  logic                 take;

  assign accept = (state_reg == IDLE) && in_valid;
  assign last   = (cnt_reg == LAST_IDX);
  assign cand   = buf_reg[cnt_reg];
  // Strictly greater keeps the lower index on ties.
  assign take   = cand > best_reg;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = (OUT == 1) ? DONE : SCAN;
        end
      end
      SCAN: begin
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Snapshot of the input vector; only the accept edge loads it, so later
  // changes on z cannot disturb a scan. Contents need no reset.
  generate
    for (genvar gi = 0; gi < OUT; gi++) begin : g_buf
      // Capture element gi on accept.
      always_ff @(posedge clk) begin
        if (accept) begin
          buf_reg[gi] <= z[gi];
        end
      end
    end
  endgenerate

  // Running maximum, scan counter and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_reg  <= '0;
      idx_reg   <= '0;
      cnt_reg   <= '0;
      out_class <= '0;
      out_max   <= '0;
    end else if (accept) begin
      best_reg <= z[0];
      idx_reg  <= '0;
      cnt_reg  <= CW'(1);
      if (OUT == 1) begin
        out_class <= '0;
        out_max   <= z[0];
      end
    end else if (state_reg == SCAN) begin
      if (take) begin
        best_reg <= cand;
        idx_reg  <= cnt_reg;
      end
      cnt_reg <= cnt_reg + CW'(1);
      // The final element's comparison feeds the result directly so the
      // result is ready as soon as DONE is entered.
      if (last) begin
        out_class <= take ? cnt_reg : idx_reg;
        out_max   <= take ? cand : best_reg;
      end
    end
  end

endmodule

// File: tb/tb_fc_argmax.sv
// Directed, table-driven bench for fc_argmax at default parameters.
module tb_fc_argmax;

  localparam int ZW  = 23;
  localparam int OUT = 10;
  localparam int CW  = 4;

  typedef struct {
    string          name;
    logic [ZW-1:0]  z [0:OUT-1];
    logic [CW-1:0]  cls;
    logic [ZW-1:0]  mx;
  } vec_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [ZW-1:0] z [0:OUT-1];
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_class;
  logic [ZW-1:0] out_max;

  int compared;
  int mismatched;

  vec_t vecs [5];
  vec_t v_fresh;

  fc_argmax dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .z         (z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_max   (out_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_all(input logic [ZW-1:0] val);
    for (int k = 0; k < OUT; k++) z[k] = val;
  endtask

  // Apply one vector, check latency and result; optionally backpressure.
  task automatic run_vec(input vec_t v, input int hold);
    int cycles;
    @(negedge clk);
    check({v.name, " in_ready before accept"}, 32'(in_ready), 32'd1);
    z         = v.z;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);                 // accept edge has passed
    in_valid = 1'b0;
    set_all(23'h3FFFFF);            // would win if z were re-sampled
    cycles = 0;
    while (!out_valid && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    check({v.name, " latency"}, 32'(cycles), 32'd9);
    check({v.name, " out_class"}, 32'(out_class), 32'(v.cls));
    check({v.name, " out_max"}, 32'(out_max), 32'(v.mx));
    $display("vec %s: class=%0d max=%06h after %0d cycles", v.name, out_class, out_max, cycles);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      set_all(23'(h + 1));
      @(negedge clk);
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp out_class", 32'(out_class), 32'(v.cls));
      check("bp out_max", 32'(out_max), 32'(v.mx));
      check("bp in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);                 // output handshake edge has passed
    out_ready = 1'b0;
    check({v.name, " out_valid after hs"}, 32'(out_valid), 32'd0);
    check({v.name, " in_ready after hs"}, 32'(in_ready), 32'd1);
    check({v.name, " class held"}, 32'(out_class), 32'(v.cls));
    check({v.name, " max held"}, 32'(out_max), 32'(v.mx));
    @(negedge clk);
    check({v.name, " idle stays idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int seen;
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    set_all('0);

    // Stimulus table.
    vecs[0].name = "single_max";
    for (int k = 0; k < OUT; k++) vecs[0].z[k] = '0;
    vecs[0].z[7] = 23'h000100;
    vecs[0].cls = 4'd7; vecs[0].mx = 23'h000100;

    vecs[1].name = "tie";
    for (int k = 0; k < OUT; k++) vecs[1].z[k] = '0;
    vecs[1].z[2] = 23'h000050;
    vecs[1].z[5] = 23'h000050;
    vecs[1].cls = 4'd2; vecs[1].mx = 23'h000050;

    vecs[2].name = "neg_desc";
    for (int k = 0; k < OUT; k++) vecs[2].z[k] = 23'(-(k + 1));
    vecs[2].cls = 4'd0; vecs[2].mx = 23'h7FFFFF;

    vecs[3].name = "signed_ext";
    for (int k = 0; k < OUT; k++) vecs[3].z[k] = 23'h7FFFFF;
    vecs[3].z[0] = 23'h400000;
    vecs[3].z[9] = 23'h3FFFFF;
    vecs[3].cls = 4'd9; vecs[3].mx = 23'h3FFFFF;

    vecs[4].name = "all_equal";
    for (int k = 0; k < OUT; k++) vecs[4].z[k] = 23'h000123;
    vecs[4].cls = 4'd0; vecs[4].mx = 23'h000123;

    v_fresh.name = "after_reset";
    for (int k = 0; k < OUT; k++) v_fresh.z[k] = 23'h7FFF00;
    v_fresh.z[4] = 23'h000010;
    v_fresh.cls = 4'd4; v_fresh.mx = 23'h000010;

    // Reset for two cycles.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_class", 32'(out_class), 32'd0);
    check("reset out_max", 32'(out_max), 32'd0);

    for (int t = 0; t < 5; t++) run_vec(vecs[t], 0);

    // Backpressure with competing input traffic.
    vecs[3].name = "backpressure";
    run_vec(vecs[3], 5);

    // Reset four cycles into a scan.
    @(negedge clk);
    z        = vecs[0].z;
    in_valid = 1'b1;
    @(negedge clk);                 // accept edge 0
    in_valid = 1'b0;
    @(negedge clk);                 // edge 1
    @(negedge clk);                 // edge 2
    @(negedge clk);                 // edge 3
    rst = 1'b1;
    @(negedge clk);                 // edge 4 is the reset edge
    rst = 1'b0;
    check("midscan in_ready", 32'(in_ready), 32'd1);
    check("midscan out_valid", 32'(out_valid), 32'd0);
    check("midscan out_class", 32'(out_class), 32'd0);
    check("midscan out_max", 32'(out_max), 32'd0);
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midscan no result", 32'(seen), 32'd0);
    $display("reset mid-scan: out_valid cycles seen=%0d", seen);

    run_vec(v_fresh, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fc_argmax.md
# fc_argmax

Sequential classifier stage placed directly downstream of the final fully-connected layer (`fc84_10`). It captures the layer's parallel output vector `z[0:OUT-1]` on a valid/ready handshake and scans it one element per cycle. It then presents the index and value of the largest signed element on a second valid/ready handshake. The result is the network's predicted class.

## Interface

Parameters:

- `WIDTH`, default 8, activation/weight width of the feeding FC layer.
- `IN`, default 84, input count of the feeding FC layer; used only to size `ZW`.
- `OUT`, default 10, number of classes (elements of `z`); must be ≥ 1.
- `ZW` (localparam), `2*WIDTH+$clog2(IN)` (23 by default), width of each `z` element.
- `CW` (localparam), `$clog2(OUT)`, or 1 when `OUT==1`; width of the class index.

Ports:

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `z` holds a valid vector.
- `in_ready`  out  1  block can accept a vector.
- `z[0:OUT-1]`  in  `ZW` each  FC layer outputs, two's-complement signed.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `out_class`  out  `CW`  index of the maximum element.
- `out_max`  out  `ZW`  value of the maximum element.

## Operation

- FSM states are IDLE, SCAN and DONE.
- IDLE:
  - `in_ready=1`.
  - On `in_valid`, copy all of `z` into an internal buffer, set `best=z[0]`, `idx=0` and counter `i=1`.
  - Go to SCAN, or to DONE directly if `OUT==1`.
- SCAN:
  - Each cycle, compare `buf[i]` with `best` using a signed comparison.
  - If `buf[i] > best` (strictly greater), load `best=buf[i]` and `idx=i`.
  - Increment `i`. When `i==OUT-1` has been processed, go to DONE.
  - Ties keep the lower index.
- DONE:
  - `out_valid=1`; `out_class=idx`, `out_max=best`.
  - On `out_valid && out_ready`, go to IDLE.
- `in_ready` equals `(state==IDLE)`. `in_valid` is ignored in SCAN and DONE, and no back-to-back bypass exists.
- The `z` input is sampled only at the accept edge; later changes to `z` have no effect.
- `out_class` and `out_max` are registered. They are held stable while `out_valid && !out_ready`.
- Both outputs keep their last value after the output handshake until the next result is written.

## Timing

- Reset, whether applied at start or mid-operation, sets:
  - state to IDLE;
  - `in_ready=1`, `out_valid=0`;
  - `out_class=0`, `out_max=0`;
  - buffer contents don't-care.
- A scan in progress is discarded and no partial result is emitted.
- `rst` has priority over every handshake in the same cycle.
- Latency: with accept at edge 0, `out_valid` is high after edge `OUT-1`, i.e. 9 cycles for `OUT=10`. For `OUT=1` it is 1 cycle.
- Output handshake at edge k gives `out_valid=0` and `in_ready=1` after edge k. The earliest next accept is edge k+1.
- Throughput is one vector per `OUT+1` cycles when `out_ready` is held high.

## Structure

- Shared package `fc_pkg`:
  - state enum `argmax_state_t` {IDLE, SCAN, DONE};
  - function `fc_out_width(width, in)` returning `2*width+$clog2(in)`, shared with the FC layer modules and benches.
- No sub-module. The comparator and counter are inline; a separate compare unit adds nothing at this size.

## Test plan

All scenarios use the default parameters (`WIDTH=8`, `IN=84`, `OUT=10`, `ZW=23`).

1. Assert `rst` for 2 cycles -> `in_ready=1`, `out_valid=0`, `out_class=0`, `out_max=0`.
2. All `z=0` except `z[7]=23'h000100`, `in_valid` pulsed 1 cycle -> `out_valid` high exactly 9 cycles after the accept edge with `out_class=7` and `out_max=23'h000100`.
3. Tie: `z[2]=z[5]=23'h000050`, all others 0 -> `out_class=2`, `out_max=23'h000050`.
4. Signed ordering, two vectors:
   - `z[i]=-(i+1)` -> `out_class=0`, `out_max=23'h7FFFFF`.
   - `z[0]=23'h400000`, `z[9]=23'h3FFFFF`, others `23'h7FFFFF` -> `out_class=9`.
5. Backpressure: hold `out_ready=0` for 5 cycles after `out_valid` rises, while driving `in_valid=1` with a different `z` -> `out_valid`, `out_class` and `out_max` are stable, and `in_ready=0` with no accept. Raising `out_ready` for 1 cycle gives `out_valid=0` and `in_ready=1` on the next cycle.
6. Reset mid-scan: assert `rst` 4 cycles after accept -> `out_valid` never rises for that vector and `in_ready=1` after the reset edge. A fresh vector with maximum at `z[4]` then yields `out_class=4` after 9 cycles.
